mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Arbitrates the single unified memory port between the icache controller and the dcache.
//  Every cycle it grants at most one requester. It forwards the memory's same-cycle response
//  number to the winner and shows 0 to the loser; the loser must hold its request and retry.
//  It records which side owns each outstanding load tag and steers each returned tag and its
//  data back to that side only.
//  It sits between both caches and the memory; it adds no cycle of latency on either path.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive icache denials that force icache priority on the next cycle
//  NUM_TAGS      16  memory tag space; tag 0 means "none", so live tags are 1..NUM_TAGS-1
// PORTS
//  clock               in   1   system clock
//  reset               in   1   synchronous, active-high
//  proc2Imem_command   in   2   icache request (BUS_NONE / BUS_LOAD)
//  proc2Imem_addr      in   64  icache request address
//  Imem2proc_response  out  4   response number shown to icache; 0 = not accepted
//  Imem2proc_tag       out  4   returned tag routed to icache; 0 otherwise
//  Imem2proc_data      out  64  returned data; equals mem2proc_data when Imem2proc_tag!=0
//  proc2Dmem_command   in   2   dcache request (BUS_NONE / BUS_LOAD / BUS_STORE)
//  proc2Dmem_addr      in   64  dcache request address
//  proc2Dmem_data      in   64  dcache store data
//  Dmem2proc_response  out  4   response number shown to dcache; 0 = not accepted
//  Dmem2proc_tag       out  4   returned tag routed to dcache; 0 otherwise
//  Dmem2proc_data      out  64  returned data; equals mem2proc_data when Dmem2proc_tag!=0
//  proc2mem_command    out  2   command driven to memory
//  proc2mem_addr       out  64  address driven to memory
//  proc2mem_data       out  64  store data driven to memory
//  mem2proc_response   in   4   memory acceptance number, combinational on proc2mem_*
//  mem2proc_tag        in   4   memory completion tag; 0 = none
//  mem2proc_data       in   64  memory completion data
//  arb_err             out  1   sticky: tag returned for an unowned entry
// BEHAVIOUR
//  Grant (combinational):
//   - Default: dcache wins when proc2Dmem_command != BUS_NONE.
//   - Override: icache wins when starve_cnt >= STARVE_LIMIT and icache is requesting.
//   - If only one side requests, it wins. If neither requests, proc2mem_command = BUS_NONE.
//  Memory mux: the winner's command, address and data drive proc2mem_*.
//   - With no winner, proc2mem_addr and proc2mem_data are 0.
//  Responses:
//   - The winner sees mem2proc_response; the loser sees 0.
//   - BUS_STORE acceptances are never recorded; stores never return a tag.
//  starve_cnt (3-bit, saturating, registered):
//   - Increments when icache requests and is denied.
//   - Clears when icache is granted or stops requesting.
//  Owner table, NUM_TAGS entries of {valid, owner}; owner 0 = icache, 1 = dcache:
//   - Allocate: on an accepted BUS_LOAD with response r != 0, set valid[r]=1 and
//     owner[r]=winner at the next clock edge.
//   - Return: on mem2proc_tag t != 0 with valid[t]=1, drive t on the owner's *_tag port
//     the same cycle and clear valid[t].
//   - Unowned return: on t != 0 with valid[t]=0, drive t to neither side and set arb_err.
//   - Simultaneous allocate and return on the same index: allocate wins, so the entry ends
//     valid with the new owner.
//   - Allocation over a still-valid entry overwrites it and sets arb_err.
//  Data: mem2proc_data is forwarded unmodified to both *_data ports.
//   - Consumers qualify data with their *_tag port.
//  Reset (synchronous):
//   - All valid bits = 0, starve_cnt = 0, arb_err = 0.
//   - Combinational outputs follow their inputs; with no requests all outputs are 0 / BUS_NONE.
//   - Reset while loads are outstanding drops them; tags returned afterwards raise arb_err.
// STRUCTURE
//  - Shared defines (sys_defs): BUS_NONE=2'd0, BUS_LOAD=2'd1, BUS_STORE=2'd2, MEM_TAG_BITS=4.
//  - Sequential updates use `SD.
//  - One sub-module: mem_tag_owner_table. It holds the valid/owner arrays and provides:
//     - alloc port: en, idx, owner
//     - lookup/free port: tag -> hit, owner
//     - arb_err generation
//  - Grant logic, muxes and starve_cnt stay in the top level.
// TESTING
//  1. Dcache LOAD 0x100 alone, mem response 3
//     -> Dmem2proc_response=3, Imem2proc_response=0
//     -> later mem2proc_tag=3 gives Dmem2proc_tag=3 and Imem2proc_tag=0.
//  2. Both request LOAD every cycle, mem always accepts
//     -> dcache wins 4 cycles, icache wins the 5th; pattern repeats; starve_cnt never exceeds 4.
//  3. Dcache STORE 0x200, data 0xDEAD, response 5
//     -> proc2mem_data=0xDEAD, no table entry
//     -> a later mem2proc_tag=5 raises arb_err and routes to neither side.
//  4. Same-cycle return of tag 7 (owner icache) and new dcache allocation of tag 7
//     -> Imem2proc_tag=7 that cycle; entry 7 is then valid with owner dcache.
//  5. Memory returns response 0 to the winner
//     -> no allocation; the winner sees 0 and retries; starve_cnt still counts a denied icache.
//  6. Reset asserted with tags 2 and 9 outstanding
//     -> table clears; mem2proc_tag=2 afterwards sets arb_err; both *_tag outputs stay 0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus encodings, tag geometry and owner encoding for the memory-port arbiter.
// Pure definitions; no state and no handshake of its own.
package mem_bus_arbiter_pkg;

    localparam int MEM_TAG_BITS = 4;
    localparam int STARVE_BITS  = 3;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef logic [MEM_TAG_BITS-1:0] mem_tag_t;
    typedef logic [STARVE_BITS-1:0]  starve_cnt_t;

    typedef enum logic {
        OWN_ICACHE = 1'b0,
        OWN_DCACHE = 1'b1
    } owner_e;

    function automatic starve_cnt_t sat_inc(input starve_cnt_t v);
        return (v == '1) ? v : v + starve_cnt_t'(1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the icache, dcache and memory sides of the unified memory port.
// slave = arbiter view; master = the caches and memory driving it.
interface mem_bus_arbiter_if;
    import mem_bus_arbiter_pkg::*;

    logic [1:0]  proc2Imem_command;
    logic [63:0] proc2Imem_addr;
    logic [3:0]  Imem2proc_response;
    mem_tag_t    Imem2proc_tag;
    logic [63:0] Imem2proc_data;

    logic [1:0]  proc2Dmem_command;
    logic [63:0] proc2Dmem_addr;
    logic [63:0] proc2Dmem_data;
    logic [3:0]  Dmem2proc_response;
    mem_tag_t    Dmem2proc_tag;
    logic [63:0] Dmem2proc_data;

    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_response;
    mem_tag_t    mem2proc_tag;
    logic [63:0] mem2proc_data;

    modport slave (
        input  proc2Imem_command, proc2Imem_addr,
        output Imem2proc_response, Imem2proc_tag, Imem2proc_data,
        input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        output Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2proc_response, mem2proc_tag, mem2proc_data
    );

    modport master (
        output proc2Imem_command, proc2Imem_addr,
        input  Imem2proc_response, Imem2proc_tag, Imem2proc_data,
        output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
        input  Dmem2proc_response, Dmem2proc_tag, Dmem2proc_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2proc_response, mem2proc_tag, mem2proc_data
    );

endinterface

// File: rtl/mem_tag_owner_table.sv
// Records which cache owns each outstanding load tag; lookup is same-cycle, updates land next edge.
// No backpressure: a lookup hit frees its entry, and a same-index allocation in that cycle wins.
module mem_tag_owner_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = 16
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     alloc_en_i,
    input  mem_tag_t alloc_idx_i,
    input  owner_e   alloc_owner_i,
    input  mem_tag_t lookup_tag_i,
    output logic     lookup_hit_o,
    output owner_e   lookup_owner_o,
    output logic     arb_err_o
);

    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [NUM_TAGS-1:0] owner_q, owner_d;
    logic                err_q, err_d;
    logic                unowned, overwrite;

    always_comb begin
        lookup_hit_o   = (lookup_tag_i != '0) && valid_q[lookup_tag_i];
        lookup_owner_o = owner_e'(owner_q[lookup_tag_i]);
        unowned        = (lookup_tag_i != '0) && !valid_q[lookup_tag_i];
        // An entry being returned this very cycle is not a live collision.
        overwrite      = alloc_en_i && valid_q[alloc_idx_i]
                         && !(lookup_hit_o && (lookup_tag_i == alloc_idx_i));

        valid_d = valid_q;
        owner_d = owner_q;
        err_d   = err_q;
        if (lookup_hit_o) begin
            valid_d[lookup_tag_i] = 1'b0;
        end
        if (alloc_en_i) begin
            valid_d[alloc_idx_i] = 1'b1;
            owner_d[alloc_idx_i] = alloc_owner_i;
        end
        if (unowned || overwrite) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            owner_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    assign arb_err_o = err_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Grants the unified memory port to icache or dcache each cycle; zero added latency both ways.
// Loser sees response 0 and must hold and retry; dcache wins unless icache has starved too long.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic               clock,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus,
    output logic               arb_err
);

    starve_cnt_t starve_cnt_q, starve_cnt_d;
    logic        i_req, d_req, i_grant, d_grant;
    logic        alloc_en, hit;
    owner_e      hit_owner;

    assign i_req   = bus.proc2Imem_command != BUS_NONE;
    assign d_req   = bus.proc2Dmem_command != BUS_NONE;
    assign i_grant = i_req && (!d_req || (starve_cnt_q >= starve_cnt_t'(STARVE_LIMIT)));
    assign d_grant = d_req && !i_grant;

    always_comb begin
        bus.proc2mem_command   = BUS_NONE;
        bus.proc2mem_addr      = '0;
        bus.proc2mem_data      = '0;
        bus.Imem2proc_response = '0;
        bus.Dmem2proc_response = '0;
        if (d_grant) begin
            bus.proc2mem_command   = bus.proc2Dmem_command;
            bus.proc2mem_addr      = bus.proc2Dmem_addr;
            bus.proc2mem_data      = bus.proc2Dmem_data;
            bus.Dmem2proc_response = bus.mem2proc_response;
        end else if (i_grant) begin
            bus.proc2mem_command   = bus.proc2Imem_command;
            bus.proc2mem_addr      = bus.proc2Imem_addr;
            bus.Imem2proc_response = bus.mem2proc_response;
        end
    end

    // Stores are fire-and-forget, so only accepted loads claim a tag.
    assign alloc_en = (i_grant || d_grant) && (bus.proc2mem_command == BUS_LOAD)
                      && (bus.mem2proc_response != '0);

    mem_tag_owner_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_owner_table (
        .clock          (clock),
        .reset          (reset),
        .alloc_en_i     (alloc_en),
        .alloc_idx_i    (bus.mem2proc_response),
        .alloc_owner_i  (d_grant ? OWN_DCACHE : OWN_ICACHE),
        .lookup_tag_i   (bus.mem2proc_tag),
        .lookup_hit_o   (hit),
        .lookup_owner_o (hit_owner),
        .arb_err_o      (arb_err)
    );

    assign bus.Imem2proc_tag  = (hit && hit_owner == OWN_ICACHE) ? bus.mem2proc_tag : '0;
    assign bus.Dmem2proc_tag  = (hit && hit_owner == OWN_DCACHE) ? bus.mem2proc_tag : '0;
    assign bus.Imem2proc_data = bus.mem2proc_data;
    assign bus.Dmem2proc_data = bus.mem2proc_data;

    assign starve_cnt_d = (i_req && !i_grant) ? sat_inc(starve_cnt_q) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
